// File: rtl/preparo_pkg.sv
// Shared brew/pump definitions: state encoding and size (modo) codes.
// Also used by the pump controller, so keep the encodings stable.
package preparo_pkg;

    typedef enum logic [2:0] {
        OCIOSO = 3'd0,
        AQUEC  = 3'd1,
        LIGA   = 3'd2,
        BOMBA  = 3'd3,
        FIM    = 3'd4,
        ERRO   = 3'd5
    } estado_t;

    localparam logic [1:0] MODO_NENHUM  = 2'b00;
    localparam logic [1:0] MODO_PEQUENO = 2'b01;
    localparam logic [1:0] MODO_GRANDE  = 2'b10;

    // Only pequeno and grande are brewable sizes.
    function automatic logic modo_valido(input logic [1:0] m);
        return (m == MODO_PEQUENO) || (m == MODO_GRANDE);
    endfunction

endpackage

// File: rtl/contador_m.sv
// Watchdog counter: synchronous clear has priority over count enable.
// Ports:
//   clock, reset_n : clock and asynchronous active-low reset
//   zera_s         : clear to zero on the next edge
//   conta          : increment on the next edge
//   valor          : current count (registered)
module contador_m #(
    parameter int unsigned N = 29
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         zera_s,
    input  logic         conta,
    output logic [N-1:0] valor
);

    logic [N-1:0] valor_q;
    logic [N-1:0] valor_d;

    // Next count.
    always_comb begin
        valor_d = valor_q;
        if (zera_s) begin
            valor_d = '0;
        end else if (conta) begin
            valor_d = valor_q + N'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valor_q <= '0;
        end else begin
            valor_q <= valor_d;
        end
    end

    assign valor = valor_q;

endmodule

// File: rtl/controle_preparo.sv
// Brew sequencer: heats water, fires one liga_bomba pulse with a stable
// modo, then waits for fim_bomba under a watchdog and reports pronto/erro.
// Optional feature macro: AQUEC_TIMEOUT_EN (heater-wait watchdog -> ERRO).
// Ports:
//   clock, reset_n        : clock, asynchronous active-low reset
//   iniciar, modo_sel     : brew request pulse and requested size
//   cancelar              : abort in AQUEC / acknowledge in ERRO
//   aquecido              : water at temperature (level)
//   aquecedor             : heater enable
//   liga_bomba, modo      : pump start pulse and size to the pump
//   fim_bomba             : pump done pulse
//   ocupado, pronto, erro : status (all registered)
module controle_preparo
    import preparo_pkg::*;
#(
    parameter int unsigned T_BOMBA = 200_500_000,
    parameter int unsigned T_AQUEC = 500_000_000,
    parameter int unsigned N       = 29
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       iniciar,
    input  logic [1:0] modo_sel,
    input  logic       cancelar,
    input  logic       aquecido,
    output logic       aquecedor,
    output logic       liga_bomba,
    output logic [1:0] modo,
    input  logic       fim_bomba,
    output logic       ocupado,
    output logic       pronto,
    output logic       erro
);

    localparam int unsigned T_MAX = (T_AQUEC > T_BOMBA) ? T_AQUEC : T_BOMBA;

    // The watchdog must be able to reach the largest limit.
    if ((64'd1 << N) <= 64'(T_MAX)) begin : g_n_pequeno
        $error("controle_preparo: N too small for watchdog limits");
    end

    estado_t    estado_q, estado_d;
    logic       aquecedor_q, aquecedor_d;
    logic       liga_bomba_q, liga_bomba_d;
    logic [1:0] modo_q, modo_d;
    logic       ocupado_q, ocupado_d;
    logic       pronto_q, pronto_d;
    logic       erro_q, erro_d;

    logic [N-1:0] wd_valor;
    logic         zera_s;
    logic         conta_s;
    logic         bomba_lim_c;

    assign bomba_lim_c = (wd_valor == N'(T_BOMBA - 1));

`ifdef AQUEC_TIMEOUT_EN
    logic aquec_lim_c;
    assign aquec_lim_c = (wd_valor == N'(T_AQUEC - 1));
    assign conta_s     = (estado_q == BOMBA) || (estado_q == AQUEC);
`else
    assign conta_s     = (estado_q == BOMBA);
`endif

    // Any state change restarts the watchdog, so it reads 0 on the first
    // cycle of AQUEC and BOMBA.
    assign zera_s = (estado_d != estado_q);

    contador_m #(.N(N)) u_watchdog (
        .clock   (clock),
        .reset_n (reset_n),
        .zera_s  (zera_s),
        .conta   (conta_s),
        .valor   (wd_valor)
    );

    // Next-state logic.
    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            OCIOSO: if (iniciar && modo_valido(modo_sel)) estado_d = AQUEC;
            AQUEC: begin
                if (cancelar) begin
                    estado_d = OCIOSO;
                end else if (aquecido) begin
                    estado_d = LIGA;
                end
`ifdef AQUEC_TIMEOUT_EN
                else if (aquec_lim_c) begin
                    estado_d = ERRO;
                end
`endif
            end
            LIGA:  estado_d = BOMBA;
            BOMBA: begin
                // fim_bomba beats a watchdog expiring in the same cycle.
                if (fim_bomba) begin
                    estado_d = FIM;
                end else if (bomba_lim_c) begin
                    estado_d = ERRO;
                end
            end
            FIM:   estado_d = OCIOSO;
            ERRO:  if (cancelar) estado_d = OCIOSO;
            default: estado_d = OCIOSO;
        endcase
    end

    // Moore outputs decoded from the state being entered.
    always_comb begin
        aquecedor_d  = (estado_d == AQUEC) || (estado_d == LIGA) || (estado_d == BOMBA);
        liga_bomba_d = (estado_d == LIGA);
        ocupado_d    = (estado_d != OCIOSO) && (estado_d != ERRO);
        pronto_d     = (estado_d == FIM);
        erro_d       = (estado_d == ERRO);
        modo_d       = modo_q;
        if ((estado_q == OCIOSO) && (estado_d == AQUEC)) begin
            modo_d = modo_sel;
        end else if ((estado_d == OCIOSO) || (estado_d == ERRO)) begin
            modo_d = MODO_NENHUM;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado_q     <= OCIOSO;
            aquecedor_q  <= 1'b0;
            liga_bomba_q <= 1'b0;
            modo_q       <= MODO_NENHUM;
            ocupado_q    <= 1'b0;
            pronto_q     <= 1'b0;
            erro_q       <= 1'b0;
        end else begin
            estado_q     <= estado_d;
            aquecedor_q  <= aquecedor_d;
            liga_bomba_q <= liga_bomba_d;
            modo_q       <= modo_d;
            ocupado_q    <= ocupado_d;
            pronto_q     <= pronto_d;
            erro_q       <= erro_d;
        end
    end

    assign aquecedor  = aquecedor_q;
    assign liga_bomba = liga_bomba_q;
    assign modo       = modo_q;
    assign ocupado    = ocupado_q;
    assign pronto     = pronto_q;
    assign erro       = erro_q;

endmodule

// File: tb/tb_controle_preparo.sv
// Bench for controle_preparo with small watchdog limits.
module tb_controle_preparo;

    localparam int unsigned T_BOMBA = 20;
    localparam int unsigned T_AQUEC = 30;
    localparam int unsigned N       = 6;

    // Reference phases of a brew, as seen by the user.
    localparam int P_IDLE  = 0;
    localparam int P_HEAT  = 1;
    localparam int P_START = 2;
    localparam int P_PUMP  = 3;
    localparam int P_DONE  = 4;
    localparam int P_FAULT = 5;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       iniciar = 1'b0;
    logic [1:0] modo_sel = 2'b00;
    logic       cancelar = 1'b0;
    logic       aquecido = 1'b0;
    logic       fim_bomba = 1'b0;
    logic       aquecedor, liga_bomba, ocupado, pronto, erro;
    logic [1:0] modo;

    int errors = 0;
    int checks = 0;

    int         m_fase = P_IDLE;
    logic [1:0] m_modo = 2'b00;
    int         m_tempo = 0;

    controle_preparo #(.T_BOMBA(T_BOMBA), .T_AQUEC(T_AQUEC), .N(N)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .iniciar    (iniciar),
        .modo_sel   (modo_sel),
        .cancelar   (cancelar),
        .aquecido   (aquecido),
        .aquecedor  (aquecedor),
        .liga_bomba (liga_bomba),
        .modo       (modo),
        .fim_bomba  (fim_bomba),
        .ocupado    (ocupado),
        .pronto     (pronto),
        .erro       (erro)
    );

    always #5 clock = ~clock;

    function automatic logic [6:0] obs();
        return {aquecedor, liga_bomba, modo, ocupado, pronto, erro};
    endfunction

    function automatic logic [6:0] esperado();
        logic aq, lg, oc, pr, er;
        aq = (m_fase == P_HEAT) || (m_fase == P_START) || (m_fase == P_PUMP);
        lg = (m_fase == P_START);
        oc = (m_fase != P_IDLE) && (m_fase != P_FAULT);
        pr = (m_fase == P_DONE);
        er = (m_fase == P_FAULT);
        return {aq, lg, m_modo, oc, pr, er};
    endfunction

    task automatic modelo_reset();
        m_fase  = P_IDLE;
        m_modo  = 2'b00;
        m_tempo = 0;
    endtask

    // Advance the reference by one clock using the inputs present at the edge.
    task automatic modelo_passo();
        case (m_fase)
            P_IDLE: if (iniciar && (modo_sel == 2'b01 || modo_sel == 2'b10)) begin
                m_fase = P_HEAT; m_modo = modo_sel; m_tempo = 0;
            end
            P_HEAT: begin
                if (cancelar) begin
                    m_fase = P_IDLE; m_modo = 2'b00;
                end else if (aquecido) begin
                    m_fase = P_START;
                end
`ifdef AQUEC_TIMEOUT_EN
                else if (m_tempo == int'(T_AQUEC) - 1) begin
                    m_fase = P_FAULT; m_modo = 2'b00;
                end
`endif
                else m_tempo++;
            end
            P_START: begin m_fase = P_PUMP; m_tempo = 0; end
            P_PUMP: begin
                if (fim_bomba) m_fase = P_DONE;
                else if (m_tempo == int'(T_BOMBA) - 1) begin
                    m_fase = P_FAULT; m_modo = 2'b00;
                end else m_tempo++;
            end
            P_DONE:  begin m_fase = P_IDLE; m_modo = 2'b00; end
            default: if (cancelar) begin m_fase = P_IDLE; m_modo = 2'b00; end
        endcase
    endtask

    // One clock: inputs sampled at the edge, outputs settle by +1.
    task automatic passo();
        @(posedge clock);
        modelo_passo();
        #1;
    endtask

    task automatic zera_entradas();
        iniciar = 1'b0; modo_sel = 2'b00; cancelar = 1'b0;
        aquecido = 1'b0; fim_bomba = 1'b0;
    endtask

    // Reset pulse placed between clock edges.
    task automatic aplica_reset();
        zera_entradas();
        reset_n = 1'b0;
        modelo_reset();
        #2;
        reset_n = 1'b1;
        passo();
    endtask

    task automatic inicia(input logic [1:0] sel);
        iniciar = 1'b1; modo_sel = sel;
        passo();
        iniciar = 1'b0; modo_sel = 2'b00;
    endtask

    task automatic test_reset();
        zera_entradas();
        reset_n = 1'b0;
        #3;
        checks++;
        if (obs() !== 7'b0) begin
            errors++; $display("FAIL reset_async: saidas=%b esperado=%b", obs(), 7'b0);
        end
        @(posedge clock); #1;
        checks++;
        if (obs() !== esperado()) begin
            errors++; $display("FAIL reset_held: saidas=%b esperado=%b", obs(), esperado());
        end
        reset_n = 1'b1;
        passo();
    endtask

    task automatic test_pequeno();
        int ligas = 0;
        aplica_reset();
        inicia(2'b01);
        for (int c = 0; c < 16; c++) begin
            aquecido  = (c == 4);
            fim_bomba = (c == 13);
            checks++;
            if (obs() !== esperado()) begin
                errors++; $display("FAIL pequeno c%0d: saidas=%b esperado=%b", c, obs(), esperado());
            end
            if (liga_bomba) begin
                ligas++;
                checks++;
                if (modo !== 2'b01) begin
                    errors++; $display("FAIL pequeno_modo: modo=%b esperado=01", modo);
                end
            end
            passo();
        end
        checks++;
        if (ligas != 1) begin
            errors++; $display("FAIL pequeno_ligas: pulsos=%0d esperado=1", ligas);
        end
        zera_entradas();
    endtask

    task automatic test_modo_invalido();
        aplica_reset();
        for (int k = 0; k < 2; k++) begin
            inicia(k == 0 ? 2'b11 : 2'b00);
            checks++;
            if (obs() !== 7'b0 || obs() !== esperado()) begin
                errors++; $display("FAIL modo_invalido %0d: saidas=%b esperado=%b", k, obs(), esperado());
            end
        end
    endtask

    task automatic test_watchdog_bomba();
        int atraso = -1;
        aplica_reset();
        inicia(2'b10);
        aquecido = 1'b1;
        passo();
        aquecido = 1'b0;
        for (int k = 1; k <= 30 && atraso < 0; k++) begin
            passo();
            checks++;
            if (obs() !== esperado()) begin
                errors++; $display("FAIL watchdog k%0d: saidas=%b esperado=%b", k, obs(), esperado());
            end
            if (erro) atraso = k;
        end
        checks++;
        if (atraso != 21) begin
            errors++; $display("FAIL watchdog_atraso: ciclos=%0d esperado=21", atraso);
        end
        cancelar = 1'b1;
        passo();
        cancelar = 1'b0;
        checks++;
        if (obs() !== 7'b0 || obs() !== esperado()) begin
            errors++; $display("FAIL watchdog_cancela: saidas=%b esperado=%b", obs(), esperado());
        end
    endtask

    task automatic test_empate();
        aplica_reset();
        inicia(2'b01);
        aquecido = 1'b1;
        passo();
        aquecido = 1'b0;
        for (int k = 0; k < 20; k++) passo();
        fim_bomba = 1'b1;
        passo();
        fim_bomba = 1'b0;
        checks++;
        if (pronto !== 1'b1 || erro !== 1'b0 || obs() !== esperado()) begin
            errors++; $display("FAIL empate: saidas=%b esperado=%b", obs(), esperado());
        end
        passo();
        checks++;
        if (erro !== 1'b0 || obs() !== esperado()) begin
            errors++; $display("FAIL empate_pos: saidas=%b esperado=%b", obs(), esperado());
        end
    endtask

    task automatic test_cancelar();
        aplica_reset();
        inicia(2'b10);
        passo();
        cancelar = 1'b1; aquecido = 1'b1;
        passo();
        cancelar = 1'b0; aquecido = 1'b0;
        checks++;
        if (obs() !== 7'b0 || obs() !== esperado()) begin
            errors++; $display("FAIL cancela_aquec: saidas=%b esperado=%b", obs(), esperado());
        end
        inicia(2'b10);
        aquecido = 1'b1;
        passo();
        aquecido = 1'b0;
        passo();
        cancelar = 1'b1; iniciar = 1'b1; modo_sel = 2'b01;
        for (int k = 0; k < 3; k++) begin
            passo();
            checks++;
            if (obs() !== esperado() || modo !== 2'b10) begin
                errors++; $display("FAIL ignora_bomba k%0d: saidas=%b esperado=%b", k, obs(), esperado());
            end
        end
        zera_entradas();
    endtask

    task automatic test_reset_bomba();
        aplica_reset();
        inicia(2'b01);
        aquecido = 1'b1;
        passo();
        aquecido = 1'b0;
        passo(); passo();
        reset_n = 1'b0;
        #2;
        checks++;
        if (obs() !== 7'b0) begin
            errors++; $display("FAIL reset_bomba: saidas=%b esperado=%b", obs(), 7'b0);
        end
        modelo_reset();
        #2;
        reset_n = 1'b1;
        passo();
        checks++;
        if (obs() !== esperado()) begin
            errors++; $display("FAIL reset_bomba_pos: saidas=%b esperado=%b", obs(), esperado());
        end
    endtask

`ifdef AQUEC_TIMEOUT_EN
    task automatic test_aquec_timeout();
        int atraso = -1;
        aplica_reset();
        inicia(2'b01);
        for (int k = 1; k <= 40 && atraso < 0; k++) begin
            passo();
            checks++;
            if (obs() !== esperado()) begin
                errors++; $display("FAIL aquec_to k%0d: saidas=%b esperado=%b", k, obs(), esperado());
            end
            if (erro) atraso = k;
        end
        checks++;
        if (atraso != 30) begin
            errors++; $display("FAIL aquec_to_atraso: ciclos=%0d esperado=30", atraso);
        end
    endtask
`endif

    task automatic test_aleatorio();
        aplica_reset();
        for (int c = 0; c < 4000; c++) begin
            iniciar   = ($urandom_range(0, 5) == 0);
            modo_sel  = 2'($urandom_range(0, 3));
            cancelar  = ($urandom_range(0, 15) == 0);
            aquecido  = ($urandom_range(0, 7) == 0);
            fim_bomba = ($urandom_range(0, 9) == 0);
            passo();
            checks++;
            if (obs() !== esperado()) begin
                errors++; $display("FAIL aleatorio c%0d: saidas=%b esperado=%b", c, obs(), esperado());
            end
        end
        zera_entradas();
    endtask

    initial begin
        test_reset();
        test_pequeno();
        test_modo_invalido();
        test_watchdog_bomba();
        test_empate();
        test_cancelar();
        test_reset_bomba();
`ifdef AQUEC_TIMEOUT_EN
        test_aquec_timeout();
`endif
        test_aleatorio();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
